truth_table_checker: RTL and testbench

//   Hardware-side exhaustive checker for a small combinational function F(A,B,C,D).

---
 rtl/tt_check_pkg.sv | 16 +
 rtl/truth_table_checker_settle_timer.sv | 33 +++
 rtl/truth_table_checker.sv | 135 +++++++++++++
 tb/tb_truth_table_checker.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/tt_check_pkg.sv
// Shared definitions for the exhaustive truth-table checker: FSM states and
// default sizing of the vector space.
package tt_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int N_IN_DEFAULT   = 4;
    localparam int SETTLE_DEFAULT = 3;
    localparam int NVEC           = 2 ** N_IN_DEFAULT;

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Settle timer: counts hold cycles for the current vector and flags the last
// one; load restarts the count from zero.
module settle_timer #(
    parameter int SETTLE = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [W-1:0] LAST = W'(SETTLE - 1);

    logic [W-1:0] cnt_r;

    // Hold counter; it parks on LAST so it can never run past the expiry value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == LAST);

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive checker: walks every input vector of F in binary order, samples F
// after a settle time, and compares the captured table against the expected one.
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int N_IN   = N_IN_DEFAULT,
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2**N_IN-1:0]    expected,
    input  logic                  f_in,
    output logic [N_IN-1:0]       vec_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2**N_IN-1:0]    captured,
    output logic [N_IN-1:0]       first_err_idx,
    output logic [N_IN:0]         err_count
);

    localparam int NV = 2 ** N_IN;

    state_e            state_r, state_s;
    logic [N_IN-1:0]   vec_r, vec_s;
    logic [NV-1:0]     exp_r, exp_s;
    logic [NV-1:0]     cap_r, cap_s;
    logic [N_IN:0]     err_r, err_s;
    logic [N_IN-1:0]   first_r, first_s;
    logic              busy_r, done_r, pass_r;
    logic              tmr_load_s, tmr_en_s, tmr_expired_s;

    settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load_s),
        .en      (tmr_en_s),
        .expired (tmr_expired_s)
    );

    // Next-state and datapath update; f_in is only looked at in SAMPLE
    always_comb begin
        state_s    = state_r;
        vec_s      = vec_r;
        exp_s      = exp_r;
        cap_s      = cap_r;
        err_s      = err_r;
        first_s    = first_r;
        tmr_load_s = 1'b0;
        tmr_en_s   = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s    = DRIVE;
                    exp_s      = expected;
                    vec_s      = '0;
                    cap_s      = '0;
                    err_s      = '0;
                    first_s    = '0;
                    tmr_load_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            DRIVE: begin
                tmr_en_s = 1'b1;
                if (tmr_expired_s) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = DRIVE;
                end
            end
            SAMPLE: begin
                cap_s[vec_r] = f_in;
                if (f_in != exp_r[vec_r]) begin
                    err_s = err_r + (N_IN+1)'(1);
                    if (err_r == '0) begin
                        first_s = vec_r;
                    end else begin
                        first_s = first_r;
                    end
                end else begin
                    err_s = err_r;
                end
                // Last vector: stay on it rather than wrapping back to zero
                if (vec_r == {N_IN{1'b1}}) begin
                    state_s = DONE;
                end else begin
                    state_s    = DRIVE;
                    vec_s      = vec_r + N_IN'(1);
                    tmr_load_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; status flags follow the next state so
    // done drops on the very edge that accepts a restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            vec_r   <= '0;
            exp_r   <= '0;
            cap_r   <= '0;
            err_r   <= '0;
            first_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            exp_r   <= exp_s;
            cap_r   <= cap_s;
            err_r   <= err_s;
            first_r <= first_s;
            busy_r  <= (state_s == DRIVE) || (state_s == SAMPLE);
            done_r  <= (state_s == DONE);
            pass_r  <= (state_s == DONE) && (err_s == '0);
        end
    end

    assign vec_out       = vec_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign captured      = cap_r;
    assign first_err_idx = first_r;
    assign err_count     = err_r;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: a registered function model
// feeds f_in, results are compared against a table-level reference model.
module tb_truth_table_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] expected;
    logic        f_in;
    logic [3:0]  vec_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] captured;
    logic [3:0]  first_err_idx;
    logic [4:0]  err_count;

    logic [15:0] dut_tbl;
    int          vectors;
    int          miscompares;

    truth_table_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .expected      (expected),
        .f_in          (f_in),
        .vec_out       (vec_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .captured      (captured),
        .first_err_idx (first_err_idx),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function under test: table lookup, registered like a real DUT output
    always @(posedge clk) f_in <= dut_tbl[vec_out];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One full run; poke pulses start and changes expected while busy
    task automatic run(input string name, input logic [15:0] exp_v,
                       input logic [15:0] tbl, input bit poke);
        logic [15:0] diff;
        int          n_err;
        int          first;
        int          edges;
        bit          seq_ok;
        diff  = tbl ^ exp_v;
        n_err = 0;
        first = -1;
        for (int i = 0; i < 16; i++) begin
            if (diff[i]) begin
                n_err++;
                if (first < 0) first = i;
            end
        end
        if (first < 0) first = 0;

        dut_tbl  = tbl;
        @(negedge clk);
        expected = exp_v;
        start    = 1'b1;
        @(posedge clk);
        #1;
        edges  = 1;
        seq_ok = (vec_out == 4'd0);
        check({name, ".accept_busy"}, {31'd0, busy}, 32'd1);
        check({name, ".accept_done"}, {31'd0, done}, 32'd0);
        start = 1'b0;
        while (!done && edges < 200) begin
            if (poke && edges == 30) begin
                start    = 1'b1;
                expected = ~exp_v;
            end else if (poke && edges == 33) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
            if (!done && vec_out != 4'((edges - 1) / 4)) seq_ok = 1'b0;
        end
        start = 1'b0;
        check({name, ".done_edge"},  edges, 32'd65);
        check({name, ".captured"},   {16'd0, captured}, {16'd0, tbl});
        check({name, ".err_count"},  {27'd0, err_count}, n_err);
        check({name, ".first_err"},  {28'd0, first_err_idx}, first);
        check({name, ".pass"},       {31'd0, pass}, (n_err == 0) ? 32'd1 : 32'd0);
        check({name, ".vec_last"},   {28'd0, vec_out}, 32'd15);
        check({name, ".vec_seq"},    {31'd0, seq_ok}, 32'd1);
        // Results must hold in DONE
        repeat (3) @(posedge clk);
        #1;
        check({name, ".hold_done"},  {31'd0, done}, 32'd1);
        check({name, ".hold_cap"},   {16'd0, captured}, {16'd0, tbl});
    endtask

    initial begin
        logic [15:0] t;
        logic [15:0] m;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        expected    = 16'h0;
        dut_tbl     = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.outs", {vec_out, busy, done, pass, captured, first_err_idx, err_count},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("and4",  16'h8000, 16'h8000, 1'b0);
        run("xor4",  16'h6996, 16'h6996, 1'b0);
        run("stuck", 16'h6996, 16'h0000, 1'b0);
        run("poke",  16'h6996, 16'h0000, 1'b1);

        // Mid-run asynchronous reset
        @(negedge clk);
        expected = 16'hA5A5;
        dut_tbl  = 16'h1234;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset.outs", {vec_out, busy, done, pass, captured, first_err_idx, err_count},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset.idle", {31'd0, busy}, 32'd0);
        run("after_rst", 16'hFFFF, 16'hFFFF, 1'b0);

        for (int r = 0; r < 5; r++) begin
            t = 16'($urandom);
            m = (r == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
            run("rand", t ^ m, t, (r == 2));
        end
        run("all_wrong", 16'h0000, 16'hFFFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
